dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle for the data-memory arbiter: core port, loader port and memory port.
// The arbiter takes the slave view; the environment (core, loader, memory) takes the master view.
interface dmem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_done;
    logic        c_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        err;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_done, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output err,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata, m_ack
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_done, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  err,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (core / loader) round-robin arbiter in front of a single data memory,
// with a per-access acknowledge timeout that completes the access with an error pulse.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    logic        owner_r;
    logic        last_r;
    logic [7:0]  cnt_r;
    logic        c_done_r;
    logic        d_done_r;
    logic        err_r;
    logic [31:0] c_rdata_r;
    logic [31:0] d_rdata_r;

    logic        c_elig_s;
    logic        d_elig_s;
    logic        grant_valid_s;
    logic        grant_sel_s;
    logic        m_en_s;
    logic        m_we_s;
    logic [31:0] m_addr_s;
    logic [31:0] m_wdata_s;
    logic        timeout_s;

    // A port whose done pulse is showing this cycle sits out one arbitration round.
    assign c_elig_s  = bus.c_req & ~c_done_r;
    assign d_elig_s  = bus.d_req & ~d_done_r;
    assign timeout_s = (cnt_r == TO_LAST);

    // Grant selection: on a tie, the port that did not win last time.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        if (c_elig_s && d_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = ~last_r;
        end else if (c_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b0;
        end else if (d_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = 1'b0;
        end
    end

    // Memory-side mux: forward the owner's request while an access is in flight.
    always_comb begin
        m_en_s    = 1'b0;
        m_we_s    = 1'b0;
        m_addr_s  = 32'h0000_0000;
        m_wdata_s = 32'h0000_0000;
        if (state_r == ACCESS) begin
            m_en_s = 1'b1;
            if (owner_r) begin
                m_we_s    = bus.d_we;
                m_addr_s  = bus.d_addr;
                m_wdata_s = bus.d_wdata;
            end else begin
                m_we_s    = bus.c_we;
                m_addr_s  = bus.c_addr;
                m_wdata_s = bus.c_wdata;
            end
        end else begin
            m_en_s    = 1'b0;
            m_we_s    = 1'b0;
            m_addr_s  = 32'h0000_0000;
            m_wdata_s = 32'h0000_0000;
        end
    end

    // Arbitration FSM with registered done/err pulses and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            cnt_r     <= 8'd0;
            c_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            err_r     <= 1'b0;
            c_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
        end else begin
            c_done_r <= 1'b0;
            d_done_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r <= ACCESS;
                        owner_r <= grant_sel_s;
                        last_r  <= grant_sel_s;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // An ack in the final allowed cycle still counts as a normal completion.
                    if (bus.m_ack) begin
                        state_r <= IDLE;
                        if (owner_r) begin
                            d_done_r <= 1'b1;
                            if (!m_we_s) begin
                                d_rdata_r <= bus.m_rdata;
                            end
                        end else begin
                            c_done_r <= 1'b1;
                            if (!m_we_s) begin
                                c_rdata_r <= bus.m_rdata;
                            end
                        end
                    end else if (timeout_s) begin
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                        if (owner_r) begin
                            d_done_r <= 1'b1;
                        end else begin
                            c_done_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.c_rdata = c_rdata_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.c_done  = c_done_r;
    assign bus.d_done  = d_done_r;
    assign bus.err     = err_r;
    assign bus.c_stall = bus.c_req & ~c_done_r;
    assign bus.m_en    = m_en_s;
    assign bus.m_we    = m_we_s;
    assign bus.m_addr  = m_addr_s;
    assign bus.m_wdata = m_wdata_s;

endmodule
